hf_lsab_turn_scheduler: RTL

Generates the 2-bit LSAB_TURN slot number shared by the hyperfabric LSAB adaptors (Steelhorse receive/collision-drain and peers), arbitrating among 4 slot requesters. Round-robin with bounded bursts, IRQ-pending priority and a one-cycle dead turn between owners. This lets adaptors whose registers clear "on my_turn" settle before the next owner.

---
 rtl/hf_pkg.sv | 19 +
 rtl/hf_rr_pick4.sv | 39 +++
 rtl/hf_lsab_turn_scheduler.sv | 138 +++++++++++++
 3 files changed

// File: rtl/hf_pkg.sv
// Shared hyperfabric LSAB definitions: turn-scheduler state encoding, slot count, adaptor slot numbers.
// Pure declarations; no latency or backpressure.
package hf_pkg;

  localparam int HF_LSAB_SLOTS = 4;

  localparam logic [1:0] HF_SLOT_STEELHORSE_CRCW = 2'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } hf_state_e;

  function automatic logic [HF_LSAB_SLOTS-1:0] slot_onehot(input logic [1:0] slot);
    return 4'b0001 << slot;
  endfunction

endpackage

// File: rtl/hf_rr_pick4.sv
// Round-robin pick of 4 rows searched from ptr+1: a row with req&pri wins first, else any req row.
// Purely combinational; zero latency, no backpressure.
module hf_rr_pick4 (
  input  logic [1:0] ptr,
  input  logic [3:0] req,
  input  logic [3:0] pri,
  output logic       found,
  output logic [1:0] idx
);

  logic       pri_hit;
  logic       req_hit;
  logic [1:0] pri_idx;
  logic [1:0] req_idx;

  always_comb begin
    logic [1:0] slot;
    pri_hit = 1'b0;
    req_hit = 1'b0;
    pri_idx = ptr;
    req_idx = ptr;
    slot    = ptr;
    // k=4 wraps back to ptr itself, so the previous owner is checked last
    for (int k = 1; k <= 4; k++) begin
      slot = ptr + 2'(k);
      if (!pri_hit && req[slot] && pri[slot]) begin
        pri_hit = 1'b1;
        pri_idx = slot;
      end
      if (!req_hit && req[slot]) begin
        req_hit = 1'b1;
        req_idx = slot;
      end
    end
    found = req_hit;
    idx   = pri_hit ? pri_idx : req_idx;
  end

endmodule

// File: rtl/hf_lsab_turn_scheduler.sv
// LSAB_TURN generator: RR over 4 slots, bounded bursts, IRQ priority, one dead GAP cycle between owners; 1-cycle REQ->GRANT.
// No backpressure; optional starvation override when HF_SCHED_STARVE_EN is defined.
module hf_lsab_turn_scheduler
  import hf_pkg::*;
#(
  parameter int         BURST_MAX    = 8,
  parameter logic [1:0] PARK_SLOT    = 2'h0,
  parameter int         STARVE_LIMIT = 32
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] REQ,
  input  logic [3:0] IRQ_PEND,
  output logic [1:0] LSAB_TURN,
  output logic       TURN_VLD,
  output logic [3:0] GRANT,
  output logic [3:0] STARVE
);

  hf_state_e  state_q, state_d;
  logic [7:0] burst_cnt, burst_d;
  logic [1:0] rr_ptr, ptr_d, turn_d;
  logic       vld_d;
  logic [3:0] grant_d;
  logic [3:0] pick_pri;
  logic       win_found;
  logic [1:0] win_idx;
  logic       take;
  logic       starve_cut;
  logic       others_req;
  logic       burst_done;

  hf_rr_pick4 u_pick (
    .ptr   (rr_ptr),
    .req   (REQ),
    .pri   (pick_pri),
    .found (win_found),
    .idx   (win_idx)
  );

  assign others_req = |(REQ & ~slot_onehot(LSAB_TURN));
  assign burst_done = (burst_cnt == 8'(BURST_MAX));

  always_comb begin
    state_d = state_q;
    turn_d  = LSAB_TURN;
    burst_d = burst_cnt;
    ptr_d   = rr_ptr;
    take    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_found) take = 1'b1;
        else           turn_d = PARK_SLOT;
      end
      ST_OWN: begin
        if (!REQ[LSAB_TURN] || (burst_done && others_req) || starve_cut) begin
          state_d = ST_GAP;
        end else if (burst_done) begin
          burst_d = 8'd1;
        end else if (burst_cnt != 8'hFF) begin
          burst_d = burst_cnt + 8'd1;
        end
      end
      ST_GAP: begin
        if (win_found) begin
          take = 1'b1;
        end else begin
          state_d = ST_IDLE;
          turn_d  = PARK_SLOT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        turn_d  = PARK_SLOT;
      end
    endcase
    if (take) begin
      state_d = ST_OWN;
      turn_d  = win_idx;
      burst_d = 8'd1;
      ptr_d   = win_idx;
    end
    vld_d   = (state_d == ST_OWN);
    grant_d = vld_d ? slot_onehot(turn_d) : 4'b0000;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      LSAB_TURN <= PARK_SLOT;
      TURN_VLD  <= 1'b0;
      GRANT     <= 4'b0000;
      burst_cnt <= 8'd0;
      rr_ptr    <= PARK_SLOT;
    end else begin
      state_q   <= state_d;
      LSAB_TURN <= turn_d;
      TURN_VLD  <= vld_d;
      GRANT     <= grant_d;
      burst_cnt <= burst_d;
      rr_ptr    <= ptr_d;
    end
  end

`ifdef HF_SCHED_STARVE_EN
  logic [7:0] wait_cnt [4];
  logic [3:0] starving;

  always_comb begin
    starving = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      starving[i] = REQ[i] && (wait_cnt[i] >= 8'(STARVE_LIMIT));
    end
  end

  // Starving slots replace the IRQ rows, so they outrank IRQ priority
  assign pick_pri   = (|starving) ? starving : (REQ & IRQ_PEND);
  assign starve_cut = |starving;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 4; i++) wait_cnt[i] <= 8'd0;
      STARVE <= 4'b0000;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!REQ[i] || grant_d[i])      wait_cnt[i] <= 8'd0;
        else if (wait_cnt[i] != 8'hFF)  wait_cnt[i] <= wait_cnt[i] + 8'd1;
      end
      STARVE <= take ? (starving & slot_onehot(win_idx)) : 4'b0000;
    end
  end
`else
  assign pick_pri   = REQ & IRQ_PEND;
  assign starve_cut = 1'b0;
  assign STARVE     = 4'b0000;
`endif

endmodule
